// File: rtl/regfile_sb_if.sv
// Register file + scoreboard bus: read ports, writeback, and destination reservation.
// The master drives selects, writeback and issue requests; the slave returns data, busy flags and issue_ready.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs1_sel;
   logic [ADDR_W-1:0] rs2_sel;
   logic [DATA_W-1:0] rs1_out;
   logic [DATA_W-1:0] rs2_out;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              we;
   logic [ADDR_W-1:0] wsel;
   logic [DATA_W-1:0] wdata;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_sel;
   logic              issue_ready;
   logic [ADDR_W-1:0] pend_cnt;

   modport master (
      output rs1_sel, rs2_sel, we, wsel, wdata, issue_valid, issue_sel,
      input  rs1_out, rs2_out, rs1_busy, rs2_busy, issue_ready, pend_cnt
   );

   modport slave (
      input  rs1_sel, rs2_sel, we, wsel, wdata, issue_valid, issue_sel,
      output rs1_out, rs2_out, rs1_busy, rs2_busy, issue_ready, pend_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending scoreboard; reads are combinational.
// Write-to-read latency 0 (BYPASS=1) or 1 cycle; an issue to a pending register is stalled via issue_ready=0.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_sb_if.slave  bus
);
   localparam int NREG = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(NREG - 1);
   localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);
   localparam bit   BYP_ON = (BYPASS != 0);

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   pend;
   logic [NREG-1:0]   pend_nxt;
   logic [ADDR_W-1:0] cnt;

   logic wr_en;
   logic iss_rdy;
   logic iss_acc;
   logic inc;
   logic dec;
   logic hit1;
   logic hit2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   assign wr_en = bus.we && (bus.wsel != '0);
   assign hit1  = BYP_ON && wr_en && (bus.wsel == bus.rs1_sel);
   assign hit2  = BYP_ON && wr_en && (bus.wsel == bus.rs2_sel);

   // A register being written this cycle frees its slot for a new producer immediately.
   assign iss_rdy = (bus.issue_sel == '0) || !pend[bus.issue_sel] ||
                    (bus.we && (bus.wsel == bus.issue_sel));
   assign iss_acc = bus.issue_valid && iss_rdy && (bus.issue_sel != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.wsel] <= bus.wdata;
      end
   end

   // Set wins over clear when issue and writeback hit the same register.
   assign pend_nxt[0] = 1'b0;
   for (genvar g = 1; g < NREG; g++) begin : g_pend
      assign pend_nxt[g] = (iss_acc && (bus.issue_sel == ADDR_W'(g))) ||
                           (pend[g] && !(wr_en && (bus.wsel == ADDR_W'(g))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   assign inc = iss_acc && !pend[bus.issue_sel];
   assign dec = wr_en && pend[bus.wsel] && !(iss_acc && (bus.issue_sel == bus.wsel));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
         end
      end else if (dec && !inc) begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   always_comb begin
      rd1 = regs[bus.rs1_sel];
      rd2 = regs[bus.rs2_sel];
      if (hit1) begin
         rd1 = bus.wdata;
      end
      if (hit2) begin
         rd2 = bus.wdata;
      end
   end

   // Outputs are forced to their idle values while reset is held, even if inputs toggle.
   assign bus.rs1_out     = rst_n ? rd1 : '0;
   assign bus.rs2_out     = rst_n ? rd2 : '0;
   assign bus.rs1_busy    = rst_n && pend[bus.rs1_sel] && !hit1;
   assign bus.rs2_busy    = rst_n && pend[bus.rs2_sel] && !hit2;
   assign bus.issue_ready = !rst_n || iss_rdy;
   assign bus.pend_cnt    = cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Drives a bypassing and a non-bypassing regfile_sb in lockstep against a queue-based scoreboard.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic rst_n;
   logic [4:0]  rs1_sel, rs2_sel, wsel, issue_sel;
   logic        we, issue_valid;
   logic [31:0] wdata;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] o1b, o2b, o1n, o2n;
      logic        b1b, b2b, b1n, b2n;
      logic        ready;
      logic [4:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   logic [31:0] m_regs [32];
   bit          m_pend [32];

   regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
   regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifn ();

   assign ifb.rs1_sel = rs1_sel;     assign ifn.rs1_sel = rs1_sel;
   assign ifb.rs2_sel = rs2_sel;     assign ifn.rs2_sel = rs2_sel;
   assign ifb.we = we;               assign ifn.we = we;
   assign ifb.wsel = wsel;           assign ifn.wsel = wsel;
   assign ifb.wdata = wdata;         assign ifn.wdata = wdata;
   assign ifb.issue_valid = issue_valid;  assign ifn.issue_valid = issue_valid;
   assign ifb.issue_sel = issue_sel;      assign ifn.issue_sel = issue_sel;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(ifb));
   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(ifn));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("byp.rs1_out", ifb.rs1_out, e.o1b);
         chk("byp.rs2_out", ifb.rs2_out, e.o2b);
         chk("nob.rs1_out", ifn.rs1_out, e.o1n);
         chk("nob.rs2_out", ifn.rs2_out, e.o2n);
         chk("byp.rs1_busy", {31'b0, ifb.rs1_busy}, {31'b0, e.b1b});
         chk("byp.rs2_busy", {31'b0, ifb.rs2_busy}, {31'b0, e.b2b});
         chk("nob.rs1_busy", {31'b0, ifn.rs1_busy}, {31'b0, e.b1n});
         chk("nob.rs2_busy", {31'b0, ifn.rs2_busy}, {31'b0, e.b2n});
         chk("byp.issue_ready", {31'b0, ifb.issue_ready}, {31'b0, e.ready});
         chk("nob.issue_ready", {31'b0, ifn.issue_ready}, {31'b0, e.ready});
         chk("byp.pend_cnt", {27'b0, ifb.pend_cnt}, {27'b0, e.cnt});
         chk("nob.pend_cnt", {27'b0, ifn.pend_cnt}, {27'b0, e.cnt});
      end
   end

   // One clock of stimulus: the expectation comes from the reference model before it advances.
   task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                       input logic [4:0] ws, input logic [31:0] wd,
                       input logic iv, input logic [4:0] is);
      exp_t e;
      bit   wr;
      int   pc;
      @(posedge clk); #1;
      rs1_sel = a1; rs2_sel = a2; we = w; wsel = ws; wdata = wd;
      issue_valid = iv; issue_sel = is;
      wr = w && (ws != 5'd0);
      e.ready = (is == 5'd0) || !m_pend[is] || (w && ws == is);
      e.o1n = m_regs[a1];
      e.o2n = m_regs[a2];
      e.o1b = (wr && ws == a1) ? wd : m_regs[a1];
      e.o2b = (wr && ws == a2) ? wd : m_regs[a2];
      e.b1n = m_pend[a1];
      e.b2n = m_pend[a2];
      e.b1b = m_pend[a1] && !(wr && ws == a1);
      e.b2b = m_pend[a2] && !(wr && ws == a2);
      pc = 0;
      for (int i = 0; i < 32; i++) pc += m_pend[i] ? 1 : 0;
      e.cnt = 5'(pc);
      exp_q.push_back(e);
      if (wr) begin
         m_regs[ws] = wd;
         m_pend[ws] = 1'b0;
      end
      if (iv && e.ready && is != 5'd0) m_pend[is] = 1'b1;
   endtask

   // Assert reset between edges with a write and an issue pending on the inputs.
   task automatic do_reset();
      exp_t e;
      @(posedge clk); #1;
      rst_n = 1'b0;
      rs1_sel = 5'd4; rs2_sel = 5'd1; we = 1'b1; wsel = 5'd4; wdata = 32'h77;
      issue_valid = 1'b1; issue_sel = 5'd6;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      e.o1b = '0; e.o2b = '0; e.o1n = '0; e.o2n = '0;
      e.b1b = 1'b0; e.b2b = 1'b0; e.b1n = 1'b0; e.b2n = 1'b0;
      e.ready = 1'b1; e.cnt = '0;
      exp_q.push_back(e);
      @(negedge clk); #2;
      we = 1'b0; issue_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst_n = 1'b1;
      rs1_sel = '0; rs2_sel = '0; we = 1'b0; wsel = '0; wdata = '0;
      issue_valid = 1'b0; issue_sel = '0;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      #1 rst_n = 1'b0;
      do_reset();

      // basic write/read and r0
      step(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      step(5'd5, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
      step(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      // same-cycle forwarding
      step(5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
      step(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      // issue r3, re-issue stalls, writeback clears
      step(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
      step(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
      step(5'd3, 5'd3, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0);
      step(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      // collision on r9
      step(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      step(5'd9, 5'd9, 1'b1, 5'd9, 32'h9999, 1'b1, 5'd9);
      step(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      step(5'd9, 5'd0, 1'b1, 5'd9, 32'h9A9A, 1'b0, 5'd0);
      // fill every register, then drain
      for (int i = 1; i < 32; i++) step(5'(i - 1), 5'(i), 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
      for (int i = 1; i < 32; i++) step(5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
      for (int i = 1; i < 32; i++) step(5'(i), 5'(i), 1'b1, 5'(i), $urandom, 1'b0, 5'd0);
      step(5'd1, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      // reset mid-operation
      step(5'd4, 5'd0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0);
      step(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
      step(5'd4, 5'd1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
      step(5'd4, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
      step(5'd4, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
      step(5'd4, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
      step(5'd4, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      do_reset();
      step(5'd4, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      // random traffic; selects often collide with wsel to exercise forwarding
      for (int n = 0; n < 600; n++) begin
         logic [4:0] ws, a1, a2, is;
         ws = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
         is = ($urandom_range(0, 5) == 0) ? ws : 5'($urandom_range(0, 31));
         step(a1, a2, 1'($urandom_range(0, 1)), ws, $urandom,
              1'($urandom_range(0, 1)), is);
      end

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 5: select width; register count is NREG = 2**ADDR_W.
REQ-003 SHALL have parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rs1_sel, input, ADDR_W: read port 1 register select.
REQ-007 SHALL have port rs2_sel, input, ADDR_W: read port 2 register select.
REQ-008 SHALL have port rs1_out, output, DATA_W: read port 1 data.
REQ-009 SHALL have port rs2_out, output, DATA_W: read port 2 data.
REQ-010 SHALL have port rs1_busy, output, 1: rs1_sel register has an outstanding producer.
REQ-011 SHALL have port rs2_busy, output, 1: rs2_sel register has an outstanding producer.
REQ-012 SHALL have port we, input, 1: writeback enable.
REQ-013 SHALL have port wsel, input, ADDR_W: writeback register select.
REQ-014 SHALL have port wdata, input, DATA_W: writeback data.
REQ-015 SHALL have port issue_valid, input, 1: request to reserve issue_sel as a pending destination.
REQ-016 SHALL have port issue_sel, input, ADDR_W: destination register to reserve.
REQ-017 SHALL have port issue_ready, output, 1: the reservation is accepted this cycle.
REQ-018 SHALL have port pend_cnt, output, ADDR_W: number of registers currently pending.

Function
REQ-019 SHALL hardwire register 0 to zero: reads return 0, writes are ignored, it is never pending, and an issue to it is accepted with no effect.
REQ-020 SHALL write wdata into register wsel on the rising clk edge when we=1 and wsel!=0.
REQ-021 SHALL make reads combinational: rsN_out = reg[rsN_sel].
REQ-022 SHALL, when BYPASS=1, drive rsN_out = wdata when we=1, wsel=rsN_sel and wsel!=0.
REQ-023 SHALL, when BYPASS=0, return the pre-write value until the cycle after the write.
REQ-024 SHALL keep one pending bit per register 1..NREG-1.
REQ-025 SHALL drive issue_ready = !pend[issue_sel] OR (we AND wsel=issue_sel), and always 1 when issue_sel=0.
REQ-026 SHALL treat an issue as accepted only when issue_valid AND issue_ready; an accepted issue sets pend[issue_sel] at the next edge.
REQ-027 SHALL treat issue_valid with issue_ready=0 as a no-op (WAW stall); the requester holds its request.
REQ-028 SHALL clear pend[wsel] at the next edge on a write with wsel!=0; a write to a non-pending register is legal and leaves the pending bits unchanged.
REQ-029 SHALL give set priority when an accepted issue and a write target the same register in one cycle: the bit ends at 1 and the data is written.
REQ-030 SHALL drive rsN_busy = pend[rsN_sel] AND NOT (BYPASS AND we AND wsel=rsN_sel), and 0 when rsN_sel=0.
REQ-031 SHALL update pend_cnt at each edge: +1 per accepted issue that sets a previously clear bit, -1 per write that clears a set bit, net 0 when both happen.
REQ-032 SHALL bound pend_cnt at NREG-1, so it never wraps.
REQ-033 SHALL have no read latency; write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.

Reset
REQ-034 SHALL, while rst_n=0, immediately clear all registers, all pending bits and pend_cnt, independent of clk.
REQ-035 SHALL, during reset, hold rs1_out=rs2_out=0, rs1_busy=rs2_busy=0 and issue_ready=1.
REQ-036 SHALL discard any write or issue coinciding with a reset assertion.
REQ-037 SHALL resume normal operation at the first clk edge after rst_n rises.

Verification
REQ-038 SHALL verify basic write/read: write 0xDEADBEEF to r5, next cycle rs1_sel=5 -> rs1_out=0xDEADBEEF; write 0x1234 to r0, then rs2_sel=0 -> rs2_out=0.
REQ-039 SHALL verify bypass: with BYPASS=1, we=1, wsel=7, wdata=0xA5A5A5A5 and rs1_sel=7 in the same cycle -> rs1_out=0xA5A5A5A5 that cycle; with BYPASS=0 -> old value that cycle, new value the next cycle.
REQ-040 SHALL verify the scoreboard: issue r3 -> next cycle rs1_busy=1 with rs1_sel=3 and pend_cnt=1; re-issue r3 -> issue_ready=0 and pend_cnt stays 1; write r3 -> rs1_busy=0 in the write cycle (BYPASS=1) and pend_cnt=0 after.
REQ-041 SHALL verify same-register collision: r9 pending, issue r9 and write r9 in one cycle -> issue_ready=1, the data is written, pend[9] stays 1 and pend_cnt is unchanged.
REQ-042 SHALL verify the count bound: issue r1..r31 on consecutive cycles -> pend_cnt=31 and every rsN_busy=1; then write all 31 -> pend_cnt=0.
REQ-043 SHALL verify reset mid-operation: with r4=0x55 and 5 registers pending, pulse rst_n low between clk edges -> r4 reads 0, pend_cnt=0 and busy=0 immediately, without waiting for a clk edge.
